// File: rtl/noc_rr_packet_ctrl.sv
// Round-robin packet arbiter: locks one source channel for a whole packet and
// forwards its flits through a one-entry registered output stage.
module noc_rr_packet_ctrl #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_FLITS = 16,
   parameter int unsigned CH_W      = $clog2(NUM_CH),
   parameter int unsigned CNT_W     = $clog2(MAX_FLITS + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        src_valid,
   input  logic [NUM_CH*DATA_W-1:0] src_data,
   input  logic [NUM_CH-1:0]        src_last,
   output logic [NUM_CH-1:0]        src_ready,
   output logic                     dst_valid,
   output logic [DATA_W-1:0]        dst_data,
   output logic                     dst_last,
   output logic [CH_W-1:0]          dst_ch,
   input  logic                     dst_ready,
   output logic                     busy,
   output logic [CNT_W-1:0]         flit_cnt,
   output logic                     err_overlen
);

   typedef enum logic {IDLE, XFER} state_e;

   state_e              state_q, state_d;
   logic [CH_W-1:0]     grant_q, grant_d;
   logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                dst_valid_q, dst_valid_d;
   logic [DATA_W-1:0]   dst_data_q, dst_data_d;
   logic                dst_last_q, dst_last_d;
   logic [CH_W-1:0]     dst_ch_q, dst_ch_d;
   logic [CNT_W-1:0]    flit_cnt_q, flit_cnt_d;
   logic                err_q, err_d;

   logic                arb_found;
   logic [CH_W-1:0]     arb_idx;
   logic [CH_W:0]       cand;
   logic                out_free;
   logic                accept;
   logic                cnt_hit;
   logic                pkt_end;
   logic [DATA_W-1:0]   sel_data;

   // First valid channel after the last served one, wrapping modulo NUM_CH
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         cand = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
         if (cand >= (CH_W+1)'(NUM_CH)) begin
            cand = cand - (CH_W+1)'(NUM_CH);
         end
         if (!arb_found && src_valid[cand[CH_W-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = cand[CH_W-1:0];
         end
      end
   end

   // Output stage can take a flit when empty or draining this cycle
   always_comb begin
      out_free  = !dst_valid_q || dst_ready;
      sel_data  = src_data[32'(grant_q)*DATA_W +: DATA_W];
      cnt_hit   = (flit_cnt_q == CNT_W'(MAX_FLITS - 1));
      pkt_end   = src_last[grant_q] || cnt_hit;
      accept    = (state_q == XFER) && src_valid[grant_q] && out_free;
      src_ready = '0;
      if (state_q == XFER) begin
         src_ready[grant_q] = out_free;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      dst_valid_d = dst_valid_q;
      dst_data_d  = dst_data_q;
      dst_last_d  = dst_last_q;
      dst_ch_d    = dst_ch_q;
      flit_cnt_d  = flit_cnt_q;
      err_d       = 1'b0;

      if (dst_valid_q && dst_ready) begin
         dst_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (arb_found) begin
               grant_d    = arb_idx;
               flit_cnt_d = '0;
               state_d    = XFER;
            end
         end
         XFER: begin
            if (accept) begin
               dst_valid_d = 1'b1;
               dst_data_d  = sel_data;
               dst_ch_d    = grant_q;
               dst_last_d  = pkt_end;
               flit_cnt_d  = flit_cnt_q + CNT_W'(1);
               err_d       = cnt_hit && !src_last[grant_q];
               if (pkt_end) begin
                  state_d  = IDLE;
                  rr_ptr_d = grant_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= CH_W'(NUM_CH - 1);
         dst_valid_q <= 1'b0;
         dst_data_q  <= '0;
         dst_last_q  <= 1'b0;
         dst_ch_q    <= '0;
         flit_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         dst_valid_q <= dst_valid_d;
         dst_data_q  <= dst_data_d;
         dst_last_q  <= dst_last_d;
         dst_ch_q    <= dst_ch_d;
         flit_cnt_q  <= flit_cnt_d;
         err_q       <= err_d;
      end
   end

   assign dst_valid   = dst_valid_q;
   assign dst_data    = dst_data_q;
   assign dst_last    = dst_last_q;
   assign dst_ch      = dst_ch_q;
   assign flit_cnt    = flit_cnt_q;
   assign err_overlen = err_q;
   assign busy        = (state_q == XFER);

endmodule

// File: tb/tb_noc_rr_packet_ctrl.sv
// Directed bench for noc_rr_packet_ctrl: per-channel flit sources plus an
// ordered expectation queue for the destination port.
module tb_noc_rr_packet_ctrl;

   typedef struct packed {
      logic [1:0]  ch;
      logic [31:0] data;
      logic        last;
   } flit_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   src_valid;
   logic [127:0] src_data;
   logic [3:0]   src_last;
   logic [3:0]   src_ready;
   logic         dst_valid;
   logic [31:0]  dst_data;
   logic         dst_last;
   logic [1:0]   dst_ch;
   logic         dst_ready;
   logic         busy;
   logic [2:0]   flit_cnt;
   logic         err_overlen;

   noc_rr_packet_ctrl #(
      .NUM_CH    (4),
      .DATA_W    (32),
      .MAX_FLITS (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_last    (src_last),
      .src_ready   (src_ready),
      .dst_valid   (dst_valid),
      .dst_data    (dst_data),
      .dst_last    (dst_last),
      .dst_ch      (dst_ch),
      .dst_ready   (dst_ready),
      .busy        (busy),
      .flit_cnt    (flit_cnt),
      .err_overlen (err_overlen)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          k[4];
   int          n[4];
   int          plen[4];
   logic [31:0] base;
   bit          gap3;
   int          phase;
   int          cyc = 0;
   int          first_hs;
   int          last_hs;
   int          err_cnt;
   logic [31:0] err_data;
   flit_t       want_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic push(input int ch, input logic [31:0] data, input bit last);
      flit_t f;
      f.ch   = 2'(ch);
      f.data = data;
      f.last = last;
      want_q.push_back(f);
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         bit v;
         v = (k[i] < n[i]);
         if (i == 3 && gap3) v = v && (phase == 0);
         src_valid[i]         = v;
         src_data[i*32 +: 32] = base + 32'(i * 256) + 32'(k[i]);
         src_last[i]          = (plen[i] != 0) && ((k[i] % plen[i]) == plen[i] - 1);
      end
   endtask

   task automatic clear_src();
      for (int i = 0; i < 4; i++) begin
         k[i]    = 0;
         n[i]    = 0;
         plen[i] = 0;
      end
      gap3  = 1'b0;
      phase = 0;
   endtask

   // One clock: score the output handshake, advance sources on accept
   task automatic tick();
      logic [3:0] acc;
      flit_t      e;
      acc = src_valid & src_ready;
      if (dst_valid && dst_ready) begin
         if (want_q.size() == 0) begin
            chk("extra_flit", 64'(dst_data), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = want_q.pop_front();
            chk("flit_data", 64'(dst_data), 64'(e.data));
            chk("flit_ch", 64'(dst_ch), 64'(e.ch));
            chk("flit_last", 64'(dst_last), 64'(e.last));
         end
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (acc[i]) k[i]++;
      end
      phase = (phase + 1) % 3;
      if (err_overlen) begin
         err_cnt++;
         err_data = dst_data;
      end
      drive();
      #1;
   endtask

   task automatic run_until_empty(input string tag, input int budget);
      for (int c = 0; c < budget && want_q.size() > 0; c++) tick();
      chk({tag, "_drain"}, 64'(want_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      dst_ready = 1'b1;
      base      = '0;
      err_cnt   = 0;
      err_data  = '0;
      first_hs  = -1;
      last_hs   = -1;
      clear_src();
      drive();
      #1;
      chk("rst_dst_valid", 64'(dst_valid), 64'd0);
      chk("rst_dst_data", 64'(dst_data), 64'd0);
      chk("rst_dst_last", 64'(dst_last), 64'd0);
      chk("rst_dst_ch", 64'(dst_ch), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_flit_cnt", 64'(flit_cnt), 64'd0);
      chk("rst_err", 64'(err_overlen), 64'd0);
      chk("rst_src_ready", 64'(src_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // ch0 three-flit packet
      base = 32'hA0; n[0] = 3; plen[0] = 3;
      drive();
      #1;
      chk("t1_idle_ready", 64'(src_ready), 64'd0);
      tick();
      chk("t1_ready_rise", 64'(src_ready), 64'b0001);
      chk("t1_busy", 64'(busy), 64'd1);
      push(0, 32'hA0, 0); push(0, 32'hA1, 0); push(0, 32'hA2, 1);
      run_until_empty("t1", 20);
      chk("t1_busy_fall", 64'(busy), 64'd0);
      chk("t1_dst_idle", 64'(dst_valid), 64'd0);

      // all channels requesting: grants 0,1,2,3,0
      clear_src();
      drive();
      do_reset();
      base = 32'h10;
      n[0] = 4; n[1] = 2; n[2] = 2; n[3] = 2;
      for (int i = 0; i < 4; i++) plen[i] = 2;
      drive();
      #1;
      for (int i = 0; i < 4; i++) begin
         push(i, 32'h10 + 32'(i * 256), 0);
         push(i, 32'h11 + 32'(i * 256), 1);
      end
      push(0, 32'h12, 0); push(0, 32'h13, 1);
      first_hs = -1;
      run_until_empty("rr", 60);
      chk("rr_span", 64'(last_hs - first_hs), 64'd13);

      // destination stall of five cycles mid-packet
      clear_src();
      base = 32'hC0; n[2] = 3; plen[2] = 3;
      drive();
      #1;
      push(2, 32'h2C0, 0); push(2, 32'h2C1, 0); push(2, 32'h2C2, 1);
      for (int c = 0; c < 20 && !dst_valid; c++) tick();
      chk("stall_start", 64'(dst_valid), 64'd1);
      dst_ready = 1'b0;
      #1;
      for (int c = 0; c < 5; c++) begin
         chk("stall_ready", 64'(src_ready), 64'd0);
         chk("stall_data", 64'(dst_data), 64'h2C0);
         chk("stall_valid", 64'(dst_valid), 64'd1);
         tick();
      end
      dst_ready = 1'b1;
      #1;
      first_hs = -1;
      run_until_empty("stall", 20);
      chk("stall_rate", 64'(last_hs - first_hs), 64'd2);

      // six flits without last: truncation at four, remainder re-arbitrated
      clear_src();
      base = 32'hD0; n[1] = 6;
      drive();
      #1;
      err_cnt = 0;
      for (int f = 0; f < 4; f++) push(1, 32'h1D0 + 32'(f), f == 3);
      push(1, 32'h1D4, 0); push(1, 32'h1D5, 0);
      run_until_empty("ovl", 60);
      tick(); tick();
      chk("ovl_pulses", 64'(err_cnt), 64'd1);
      chk("ovl_err_flit", 64'(err_data), 64'h1D3);
      chk("ovl_busy", 64'(busy), 64'd1);
      chk("ovl_cnt", 64'(flit_cnt), 64'd2);

      // reset asserted mid-packet
      clear_src();
      drive();
      do_reset();
      base = 32'hE0; n[0] = 4; plen[0] = 4;
      drive();
      #1;
      for (int c = 0; c < 20 && !(busy && flit_cnt == 3'd1); c++) tick();
      chk("mid_pkt_cnt", 64'(flit_cnt), 64'd1);
      reset = 1'b0;
      #1;
      chk("abort_dst_valid", 64'(dst_valid), 64'd0);
      chk("abort_dst_data", 64'(dst_data), 64'd0);
      chk("abort_dst_last", 64'(dst_last), 64'd0);
      chk("abort_dst_ch", 64'(dst_ch), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_cnt", 64'(flit_cnt), 64'd0);
      chk("abort_err", 64'(err_overlen), 64'd0);
      chk("abort_ready", 64'(src_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      want_q.delete();
      for (int i = 0; i < 4; i++) k[i] = 0;
      drive();
      reset = 1'b1;
      #1;
      tick();
      chk("rearb_busy", 64'(busy), 64'd1);
      chk("rearb_cnt", 64'(flit_cnt), 64'd0);
      chk("rearb_dst_valid", 64'(dst_valid), 64'd0);
      chk("rearb_ready", 64'(src_ready), 64'b0001);
      for (int f = 0; f < 4; f++) push(0, 32'hE0 + 32'(f), f == 3);
      run_until_empty("rearb", 20);

      // gapped valid on granted ch3 while ch0 keeps requesting
      clear_src();
      base = 32'hF0;
      n[3] = 4; plen[3] = 4; gap3 = 1'b1; phase = 0;
      n[0] = 2; plen[0] = 2;
      drive();
      #1;
      err_cnt = 0;
      for (int f = 0; f < 4; f++) push(3, 32'h3F0 + 32'(f), f == 3);
      push(0, 32'hF0, 0); push(0, 32'hF1, 1);
      for (int c = 0; c < 80 && want_q.size() > 0; c++) begin
         tick();
         if (busy && k[3] < 4) begin
            chk("gap_cnt", 64'(flit_cnt), 64'(k[3]));
            chk("gap_excl", 64'(src_ready[2:0]), 64'd0);
         end
      end
      chk("gap_drain", 64'(want_q.size()), 64'd0);
      chk("gap_no_err", 64'(err_cnt), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
